apb_lite_master: RTL and testbench
==================================

# apb_lite_master

Single-outstanding APB initiator for the smart_run SoC peripheral subsystem. It converts a valid/ready request stream from the system interconnect into APB2-style setup/access transfers. It decodes each request to one of `NUM_SLV` peripheral windows and drives slaves that have no `pready`/`pslverr`, such as the UART register block. The block is the initiating end of the APB interface that the peripherals respond to.

## Interface
Parameters:
- `NUM_SLV`, 4: number of APB slaves, 1..8.
- `BASE_ADDR`, 40'h00_1000_0000: base of the peripheral region, aligned to `2^(SLV_SHIFT+3)`.
- `SLV_SHIFT`, 12: log2 of the per-slave window size (4 KB).

Ports:
- `sys_clk` in 1: sole clock; all logic rises on it.
- `rst` in 1: asynchronous, active-high reset.
- `req_vld` in 1: request valid.
- `req_rdy` out 1: request accepted when `req_vld && req_rdy` at a clock edge.
- `req_addr` in 40: byte address.
- `req_write` in 1: 1 selects write, 0 selects read.
- `req_wdata` in 32: write data.
- `rsp_vld` out 1: response valid.
- `rsp_rdy` in 1: response consumed when `rsp_vld && rsp_rdy`.
- `rsp_rdata` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: address is unmapped.
- `apb_paddr` out 40: APB address.
- `apb_psel` out NUM_SLV: one-hot slave select.
- `apb_penable` out 1: high in the access phase.
- `apb_pwrite` out 1: APB direction.
- `apb_pwdata` out 32: APB write data.
- `apb_prdata` in NUM_SLV*32: flattened slave read data; slave i occupies bits `[32*i +: 32]`.

## Operation
- FSM has four states:
  - IDLE: `req_rdy=1`.
  - SETUP: `psel[idx]=1`, `penable=0`.
  - ACCESS: `psel[idx]=1`, `penable=1`.
  - RESP: `rsp_vld=1`.
- On accept, `req_addr`, `req_write`, `req_wdata` and the decoded index are captured into registers. The APB outputs are driven only from these registers.
- Address decode: the request is mapped if both of the following hold; otherwise it is unmapped.
  - `req_addr[39:SLV_SHIFT+3] == BASE_ADDR[39:SLV_SHIFT+3]`.
  - `idx = req_addr[SLV_SHIFT +: 3] < NUM_SLV`.
- Transitions:
  - IDLE, mapped accept -> SETUP.
  - IDLE, unmapped accept -> RESP with `rsp_err=1`, `rsp_rdata=0`, and no APB cycle.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> RESP. For reads, `rsp_rdata` takes `apb_prdata[32*idx +: 32]` sampled at the ACCESS edge. For writes, `rsp_rdata=0`. `rsp_err=0` in both cases.
  - RESP, `rsp_rdy=0`: stay in RESP; `rsp_*` held stable.
  - RESP, `rsp_rdy=1`, no `req_vld`: -> IDLE.
- Back-to-back: `req_rdy = (state==IDLE) || (state==RESP && rsp_rdy)`. In RESP, if `rsp_rdy` and `req_vld` occur in the same cycle, the response retires and the new request is accepted in that cycle, going to SETUP or RESP according to its decode.
- Between transfers, `apb_paddr`, `apb_pwrite` and `apb_pwdata` hold their last values. `psel` and `penable` are 0 outside SETUP/ACCESS.
- Read data is sampled only from the selected slave. All other `apb_prdata` lanes are ignored.

## Timing
- Reset values: state IDLE, `req_rdy=1`, `rsp_vld=0`, `rsp_err=0`, `rsp_rdata=0`, `apb_psel=0`, `apb_penable=0`, `apb_pwrite=0`, `apb_paddr=0`, `apb_pwdata=0`.
- Mapped request accepted at edge 0:
  - SETUP is visible in cycle 1.
  - ACCESS is visible in cycle 2.
  - `rsp_vld` is visible in cycle 3.
  - Minimum period is 3 cycles per transfer with `rsp_rdy` tied high.
- Unmapped request accepted at edge 0: `rsp_vld` in cycle 1.
- `paddr`, `pwrite`, `pwdata` and `psel` are stable from SETUP through ACCESS, as the APB rule requires.
- `rst` asserted at any point, including mid-ACCESS: all outputs go to reset values asynchronously, and the in-flight transaction is dropped with no response. Deassertion is synchronized externally.

## Structure
- Shared package `apb_pkg` holds:
  - the state encoding constants `APB_IDLE`, `APB_SETUP`, `APB_ACCESS`, `APB_RESP` (2-bit);
  - `APB_AW=40` and `APB_DW=32`.
- One sub-module, `apb_addr_dec`: combinational decode of `req_addr` to `idx` and `hit`. The FSM, capture registers and read mux stay in `apb_lite_master`.

## Test plan
- Read slave 1:
  - Stimulus: `req_addr=40'h00_1000_1008`, `req_write=0`, slave 1 drives `prdata=32'hA5A5_0001`.
  - Required: `psel=4'b0010` with `penable=0` in cycle 1 and `penable=1` in cycle 2; `rsp_vld` in cycle 3 with `rdata=32'hA5A5_0001`, `err=0`.
- Write slave 3:
  - Stimulus: `req_addr=40'h00_1000_3000`, `wdata=32'h0000_0083`.
  - Required: `pwrite=1`, `pwdata=32'h83` stable through SETUP and ACCESS; `rsp_rdata=0`.
- Unmapped addresses:
  - Stimulus: `40'h00_2000_0000`, and `40'h00_1000_5000` with `NUM_SLV=4`.
  - Required: `rsp_err=1` one cycle after accept; `psel` never asserts.
- Backpressure:
  - Stimulus: `rsp_rdy=0` for 5 cycles after a read.
  - Required: `rsp_vld` and `rsp_rdata` held; `req_rdy=0`; no second APB cycle starts.
- Back-to-back: with `rsp_rdy=1` and `req_vld` continuously high for 4 requests, a new SETUP begins every 3 cycles.
- Reset mid-ACCESS: assert `rst` in cycle 2; `psel` and `penable` drop in the same cycle, and after release the first request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

   localparam int APB_AW = 40;
   localparam int APB_DW = 32;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2,
      APB_RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_lite_master_if.sv
// Request/response stream plus APB bus bundle for the APB initiator.
// Latency: n/a (wires only).
// Backpressure: req_rdy / rsp_rdy handshakes; APB side has no pready.
interface apb_lite_master_if #(
   parameter int NUM_SLV = 4
);

   logic                            req_vld;
   logic                            req_rdy;
   logic [apb_pkg::APB_AW-1:0]      req_addr;
   logic                            req_write;
   logic [apb_pkg::APB_DW-1:0]      req_wdata;

   logic                            rsp_vld;
   logic                            rsp_rdy;
   logic [apb_pkg::APB_DW-1:0]      rsp_rdata;
   logic                            rsp_err;

   logic [apb_pkg::APB_AW-1:0]      apb_paddr;
   logic [NUM_SLV-1:0]              apb_psel;
   logic                            apb_penable;
   logic                            apb_pwrite;
   logic [apb_pkg::APB_DW-1:0]      apb_pwdata;
   logic [NUM_SLV*apb_pkg::APB_DW-1:0] apb_prdata;

   modport master (
      input  req_vld, req_addr, req_write, req_wdata, rsp_rdy, apb_prdata,
      output req_rdy, rsp_vld, rsp_rdata, rsp_err,
      output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
   );

   modport slave (
      output req_vld, req_addr, req_write, req_wdata, rsp_rdy, apb_prdata,
      input  req_rdy, rsp_vld, rsp_rdata, rsp_err,
      input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
   );

endinterface

// File: rtl/apb_addr_dec.sv
// Decodes a request address into a peripheral window index and a hit flag.
// Latency: combinational.
// Backpressure: none.
module apb_addr_dec
   import apb_pkg::*;
#(
   parameter int               NUM_SLV   = 4,
   parameter logic [APB_AW-1:0] BASE_ADDR = 40'h00_1000_0000,
   parameter int               SLV_SHIFT = 12
) (
   input  logic [APB_AW-1:0] req_addr,
   output logic [2:0]        idx,
   output logic              hit
);

   // Region match on the upper bits, then the 3-bit window index must name a populated slave.
   always_comb begin
      idx = req_addr[SLV_SHIFT +: 3];
      hit = (req_addr[APB_AW-1:SLV_SHIFT+3] == BASE_ADDR[APB_AW-1:SLV_SHIFT+3]) &&
            (32'(idx) < 32'(NUM_SLV));
   end

endmodule

// File: rtl/apb_lite_master.sv
// Single-outstanding APB initiator: request stream -> SETUP/ACCESS transfer -> response.
// Latency: 3 cycles accept-to-rsp_vld when mapped, 1 cycle when unmapped.
// Backpressure: req_rdy only in IDLE or retiring RESP; RESP holds until rsp_rdy.
module apb_lite_master
   import apb_pkg::*;
#(
   parameter int               NUM_SLV   = 4,
   parameter logic [APB_AW-1:0] BASE_ADDR = 40'h00_1000_0000,
   parameter int               SLV_SHIFT = 12
) (
   input  logic              sys_clk,
   input  logic              rst,
   apb_lite_master_if.master bus
);

   apb_state_e          state_q, state_d;
   logic [2:0]          dec_idx;
   logic                dec_hit;
   logic                req_rdy;
   logic                accept;

   logic [APB_AW-1:0]   addr_q;
   logic                write_q;
   logic [APB_DW-1:0]   wdata_q;
   logic [2:0]          idx_q;
   logic [APB_DW-1:0]   rdata_q;
   logic                err_q;
   logic [APB_DW-1:0]   sel_rdata;
   logic [NUM_SLV-1:0]  psel;

   apb_addr_dec #(
      .NUM_SLV   (NUM_SLV),
      .BASE_ADDR (BASE_ADDR),
      .SLV_SHIFT (SLV_SHIFT)
   ) u_dec (
      .req_addr (bus.req_addr),
      .idx      (dec_idx),
      .hit      (dec_hit)
   );

   assign accept = bus.req_vld && req_rdy;

   // State register; reset drops any in-flight transfer without a response.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) state_q <= APB_IDLE;
      else     state_q <= state_d;
   end

   // Next state and request-ready; RESP can retire and accept in the same cycle.
   always_comb begin
      state_d = state_q;
      req_rdy = 1'b0;
      case (state_q)
         APB_IDLE: begin
            req_rdy = 1'b1;
            if (bus.req_vld) state_d = dec_hit ? APB_SETUP : APB_RESP;
         end
         APB_SETUP:  state_d = APB_ACCESS;
         APB_ACCESS: state_d = APB_RESP;
         APB_RESP: begin
            if (bus.rsp_rdy) begin
               req_rdy = 1'b1;
               if (bus.req_vld) state_d = dec_hit ? APB_SETUP : APB_RESP;
               else             state_d = APB_IDLE;
            end
         end
         default: state_d = APB_IDLE;
      endcase
   end

   // Capture the request on accept; latch read data at the end of ACCESS.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         idx_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= bus.req_addr;
         write_q <= bus.req_write;
         wdata_q <= bus.req_wdata;
         idx_q   <= dec_idx;
         rdata_q <= '0;
         err_q   <= !dec_hit;
      end else if (state_q == APB_ACCESS) begin
         rdata_q <= write_q ? '0 : sel_rdata;
         err_q   <= 1'b0;
      end
   end

   // Read-data mux: only the selected slave's lane is looked at.
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == 3'(i)) sel_rdata = bus.apb_prdata[APB_DW*i +: APB_DW];
      end
   end

   // One-hot select, live only during SETUP and ACCESS.
   always_comb begin
      psel = '0;
      if (state_q == APB_SETUP || state_q == APB_ACCESS) begin
         for (int i = 0; i < NUM_SLV; i++) psel[i] = (idx_q == 3'(i));
      end
   end

   assign bus.req_rdy     = req_rdy;
   assign bus.rsp_vld     = (state_q == APB_RESP);
   assign bus.rsp_rdata   = rdata_q;
   assign bus.rsp_err     = err_q;
   assign bus.apb_paddr   = addr_q;
   assign bus.apb_psel    = psel;
   assign bus.apb_penable = (state_q == APB_ACCESS);
   assign bus.apb_pwrite  = write_q;
   assign bus.apb_pwdata  = wdata_q;

endmodule

// File: tb/tb_apb_lite_master.sv
// Directed bench for apb_lite_master: reset, read, write, unmapped, backpressure,
// back-to-back throughput and reset during ACCESS.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_apb_lite_master;
   import apb_pkg::*;

   localparam int NUM_SLV = 4;

   logic        clk;
   logic        rst;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] lane [NUM_SLV];

   apb_lite_master_if #(.NUM_SLV(NUM_SLV)) bus ();

   apb_lite_master #(
      .NUM_SLV   (NUM_SLV),
      .BASE_ADDR (40'h00_1000_0000),
      .SLV_SHIFT (12)
   ) dut (
      .sys_clk (clk),
      .rst     (rst),
      .bus     (bus)
   );

   assign bus.apb_prdata = {lane[3], lane[2], lane[1], lane[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_vld = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0;
      bus.req_wdata = '0; bus.rsp_rdy = 1'b0;
      #3;
      checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL rst_req_rdy: got %b want 1", bus.req_rdy); end
      checks++; if (bus.rsp_vld !== 1'b0) begin errors++; $display("FAIL rst_rsp_vld: got %b want 0", bus.rsp_vld); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
      checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
      checks++; if (bus.apb_psel !== 4'b0) begin errors++; $display("FAIL rst_psel: got %b want 0000", bus.apb_psel); end
      checks++; if (bus.apb_penable !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b want 0", bus.apb_penable); end
      checks++; if (bus.apb_pwrite !== 1'b0) begin errors++; $display("FAIL rst_pwrite: got %b want 0", bus.apb_pwrite); end
      checks++; if (bus.apb_paddr !== 40'h0) begin errors++; $display("FAIL rst_paddr: got %h want 0", bus.apb_paddr); end
      checks++; if (bus.apb_pwdata !== 32'h0) begin errors++; $display("FAIL rst_pwdata: got %h want 0", bus.apb_pwdata); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read_slave1();
      bus.req_vld = 1'b1; bus.req_addr = 40'h00_1000_1008; bus.req_write = 1'b0;
      tick();
      bus.req_vld = 1'b0;
      checks++; if (bus.apb_psel !== 4'b0010) begin errors++; $display("FAIL rd1_psel_c1: got %b want 0010", bus.apb_psel); end
      checks++; if (bus.apb_penable !== 1'b0) begin errors++; $display("FAIL rd1_penable_c1: got %b want 0", bus.apb_penable); end
      checks++; if (bus.apb_paddr !== 40'h00_1000_1008) begin errors++; $display("FAIL rd1_paddr: got %h want 0010001008", bus.apb_paddr); end
      checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL rd1_req_rdy_c1: got %b want 0", bus.req_rdy); end
      tick();
      checks++; if (bus.apb_psel !== 4'b0010) begin errors++; $display("FAIL rd1_psel_c2: got %b want 0010", bus.apb_psel); end
      checks++; if (bus.apb_penable !== 1'b1) begin errors++; $display("FAIL rd1_penable_c2: got %b want 1", bus.apb_penable); end
      checks++; if (bus.rsp_vld !== 1'b0) begin errors++; $display("FAIL rd1_rsp_vld_c2: got %b want 0", bus.rsp_vld); end
      tick();
      checks++; if (bus.rsp_vld !== 1'b1) begin errors++; $display("FAIL rd1_rsp_vld_c3: got %b want 1", bus.rsp_vld); end
      checks++; if (bus.rsp_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL rd1_rdata: got %h want a5a50001", bus.rsp_rdata); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rd1_err: got %b want 0", bus.rsp_err); end
      checks++; if (bus.apb_psel !== 4'b0) begin errors++; $display("FAIL rd1_psel_c3: got %b want 0000", bus.apb_psel); end
      bus.rsp_rdy = 1'b1;
      tick();
      bus.rsp_rdy = 1'b0;
      checks++; if (bus.rsp_vld !== 1'b0) begin errors++; $display("FAIL rd1_retire: got %b want 0", bus.rsp_vld); end
      checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL rd1_idle_rdy: got %b want 1", bus.req_rdy); end
   endtask

   task automatic test_unmapped();
      logic [39:0] addrs [2];
      addrs[0] = 40'h00_2000_0000;
      addrs[1] = 40'h00_1000_5000;
      for (int k = 0; k < 2; k++) begin
         bus.req_vld = 1'b1; bus.req_addr = addrs[k]; bus.req_write = 1'b0;
         tick();
         bus.req_vld = 1'b0;
         checks++; if (bus.rsp_vld !== 1'b1) begin errors++; $display("FAIL unm%0d_rsp_vld: got %b want 1", k, bus.rsp_vld); end
         checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL unm%0d_err: got %b want 1", k, bus.rsp_err); end
         checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL unm%0d_rdata: got %h want 0", k, bus.rsp_rdata); end
         checks++; if (bus.apb_psel !== 4'b0) begin errors++; $display("FAIL unm%0d_psel: got %b want 0000", k, bus.apb_psel); end
         bus.rsp_rdy = 1'b1;
         tick();
         bus.rsp_rdy = 1'b0;
         checks++; if (bus.apb_psel !== 4'b0 || bus.rsp_vld !== 1'b0) begin errors++; $display("FAIL unm%0d_after: psel=%b rsp_vld=%b want 0000/0", k, bus.apb_psel, bus.rsp_vld); end
      end
   endtask

   task automatic test_write_slave3();
      bus.req_vld = 1'b1; bus.req_addr = 40'h00_1000_3000; bus.req_write = 1'b1;
      bus.req_wdata = 32'h0000_0083;
      tick();
      bus.req_vld = 1'b0; bus.req_write = 1'b0; bus.req_wdata = 32'hFFFF_FFFF;
      checks++; if (bus.apb_psel !== 4'b1000 || bus.apb_penable !== 1'b0) begin errors++; $display("FAIL wr3_setup: psel=%b pen=%b want 1000/0", bus.apb_psel, bus.apb_penable); end
      checks++; if (bus.apb_pwrite !== 1'b1 || bus.apb_pwdata !== 32'h83) begin errors++; $display("FAIL wr3_setup_data: pwrite=%b pwdata=%h want 1/00000083", bus.apb_pwrite, bus.apb_pwdata); end
      checks++; if (bus.apb_paddr !== 40'h00_1000_3000) begin errors++; $display("FAIL wr3_paddr: got %h want 0010003000", bus.apb_paddr); end
      tick();
      checks++; if (bus.apb_psel !== 4'b1000 || bus.apb_penable !== 1'b1) begin errors++; $display("FAIL wr3_access: psel=%b pen=%b want 1000/1", bus.apb_psel, bus.apb_penable); end
      checks++; if (bus.apb_pwrite !== 1'b1 || bus.apb_pwdata !== 32'h83) begin errors++; $display("FAIL wr3_access_data: pwrite=%b pwdata=%h want 1/00000083", bus.apb_pwrite, bus.apb_pwdata); end
      tick();
      checks++; if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL wr3_rsp: vld=%b rdata=%h err=%b want 1/0/0", bus.rsp_vld, bus.rsp_rdata, bus.rsp_err); end
      checks++; if (bus.apb_pwdata !== 32'h83) begin errors++; $display("FAIL wr3_hold: pwdata=%h want 00000083", bus.apb_pwdata); end
      bus.rsp_rdy = 1'b1;
      tick();
      bus.rsp_rdy = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.req_vld = 1'b1; bus.req_addr = 40'h00_1000_2000; bus.req_write = 1'b0;
      tick();
      bus.req_addr = 40'h00_1000_0000;
      tick();
      tick();
      checks++; if (bus.rsp_rdata !== 32'hDEAD_0002) begin errors++; $display("FAIL bp_rdata: got %h want dead0002", bus.rsp_rdata); end
      lane[2] = 32'h1234_5678;
      for (int c = 0; c < 5; c++) begin
         checks++; if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_0002) begin errors++; $display("FAIL bp_hold%0d: vld=%b rdata=%h want 1/dead0002", c, bus.rsp_vld, bus.rsp_rdata); end
         checks++; if (bus.req_rdy !== 1'b0 || bus.apb_psel !== 4'b0) begin errors++; $display("FAIL bp_stall%0d: req_rdy=%b psel=%b want 0/0000", c, bus.req_rdy, bus.apb_psel); end
         tick();
      end
      bus.rsp_rdy = 1'b1;
      #1;
      checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b want 1", bus.req_rdy); end
      tick();
      bus.req_vld = 1'b0;
      checks++; if (bus.apb_psel !== 4'b0001 || bus.apb_penable !== 1'b0) begin errors++; $display("FAIL bp_next_setup: psel=%b pen=%b want 0001/0", bus.apb_psel, bus.apb_penable); end
      tick();
      tick();
      checks++; if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_0000) begin errors++; $display("FAIL bp_next_rsp: vld=%b rdata=%h want 1/dead0000", bus.rsp_vld, bus.rsp_rdata); end
      tick();
      bus.rsp_rdy = 1'b0;
      lane[2] = 32'hDEAD_0002;
   endtask

   task automatic test_back_to_back();
      logic setup_now;
      int   n;
      bus.rsp_rdy = 1'b1; bus.req_vld = 1'b1; bus.req_write = 1'b0;
      bus.req_addr = 40'h00_1000_0000;
      tick();
      for (int c = 1; c <= 12; c++) begin
         n = (c - 1) / 3;
         setup_now = (bus.apb_psel != 4'b0) && !bus.apb_penable;
         checks++; if (setup_now !== (c % 3 == 1)) begin errors++; $display("FAIL b2b_setup_c%0d: got %b want %b", c, setup_now, (c % 3 == 1)); end
         if (c % 3 == 1) begin
            checks++; if (bus.apb_psel !== 4'(1 << n)) begin errors++; $display("FAIL b2b_psel_c%0d: got %b want %b", c, bus.apb_psel, 4'(1 << n)); end
         end
         if (c % 3 == 0) begin
            checks++; if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== lane[n]) begin errors++; $display("FAIL b2b_rsp_c%0d: vld=%b rdata=%h want 1/%h", c, bus.rsp_vld, bus.rsp_rdata, lane[n]); end
            if (n < 3) bus.req_addr = 40'h00_1000_0000 | (40'(n + 1) << 12);
            else       bus.req_vld = 1'b0;
         end
         tick();
      end
      checks++; if (bus.rsp_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_end: vld=%b req_rdy=%b want 0/1", bus.rsp_vld, bus.req_rdy); end
      bus.rsp_rdy = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      bus.req_vld = 1'b1; bus.req_addr = 40'h00_1000_3004; bus.req_write = 1'b0;
      tick();
      bus.req_vld = 1'b0;
      tick();
      checks++; if (bus.apb_psel !== 4'b1000 || bus.apb_penable !== 1'b1) begin errors++; $display("FAIL rma_access: psel=%b pen=%b want 1000/1", bus.apb_psel, bus.apb_penable); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.apb_psel !== 4'b0 || bus.apb_penable !== 1'b0) begin errors++; $display("FAIL rma_drop: psel=%b pen=%b want 0000/0", bus.apb_psel, bus.apb_penable); end
      checks++; if (bus.req_rdy !== 1'b1 || bus.rsp_vld !== 1'b0 || bus.apb_paddr !== 40'h0) begin errors++; $display("FAIL rma_outs: req_rdy=%b rsp_vld=%b paddr=%h want 1/0/0", bus.req_rdy, bus.rsp_vld, bus.apb_paddr); end
      #1;
      rst = 1'b0;
      tick();
      tick();
      checks++; if (bus.rsp_vld !== 1'b0 || bus.apb_psel !== 4'b0) begin errors++; $display("FAIL rma_no_rsp: vld=%b psel=%b want 0/0000", bus.rsp_vld, bus.apb_psel); end
      bus.req_vld = 1'b1; bus.req_addr = 40'h00_1000_1008;
      tick();
      bus.req_vld = 1'b0;
      checks++; if (bus.apb_psel !== 4'b0010 || bus.apb_penable !== 1'b0) begin errors++; $display("FAIL rma_recover_setup: psel=%b pen=%b want 0010/0", bus.apb_psel, bus.apb_penable); end
      tick();
      tick();
      checks++; if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== 32'hA5A5_0001 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rma_recover_rsp: vld=%b rdata=%h err=%b want 1/a5a50001/0", bus.rsp_vld, bus.rsp_rdata, bus.rsp_err); end
      bus.rsp_rdy = 1'b1;
      tick();
      bus.rsp_rdy = 1'b0;
   endtask

   initial begin
      lane[0] = 32'hDEAD_0000;
      lane[1] = 32'hA5A5_0001;
      lane[2] = 32'hDEAD_0002;
      lane[3] = 32'hDEAD_0003;
      test_reset();
      test_read_slave1();
      test_unmapped();
      test_write_slave3();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
